out_port_uart: RTL and testbench
================================

# out_port_uart

CPU output stage. Captures each byte the CPU drives onto `dbus` during an OUT instruction, buffers the bytes in a small FIFO, and serialises them as 8N1 UART frames on `tx`. It sits directly downstream of `whole_cpu`, next to the simulation monitor, and gives the CPU's output a real serial device in place of a waveform-only view.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 4: clock cycles per UART bit. Legal range 1..255.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, 2..64.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low. 0 = reset, sampled on `clk` rising edge.
- `dbus`  in  8  CPU data bus. Sampled only when `out_strobe` = 1.
- `out_strobe`  in  1  CPU control bit for OUT. High for exactly one cycle per OUT instruction.
- `tx`  out  1  serial output, idle high.
- `full`  out  1  FIFO holds `DEPTH` entries.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky. Set when a strobe is dropped; cleared only by reset.
- `busy`  out  1  high while a frame is in progress (any state other than IDLE).

## Operation
- Push: on an edge with `out_strobe`=1 and `full`=0, write `dbus` to the tail.
  - `full` is evaluated before any same-cycle pop. A strobe arriving while `full`=1 is dropped and sets `overflow`, even if a pop happens on the same edge.
- Pop: the transmitter pops the head when it starts a frame. Push and pop on the same edge leave `count` unchanged.
- Transmitter FSM: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If `empty`=0: load the head byte into the shift register, pop, go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: drive 8 bits, LSB first, each for `CLKS_PER_BIT` cycles. A 3-bit bit index runs 0..7, then go to STOP.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles. On the last STOP cycle, if `empty`=0, load, pop and go straight to START; otherwise go to IDLE.
- Bit timer: counts 0..`CLKS_PER_BIT`-1. It advances the FSM or bit index on the terminal count and reloads 0 on every state entry.
- Reset values: `tx`=1, `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0, FSM=IDLE, read and write pointers = 0.
- Reset mid-frame: on the reset edge, abort the frame, flush the FIFO and force `tx`=1. No partial stop bit is sent.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`. `count` is tracked separately and is never derived from pointer difference alone.

## Timing
- Strobe sampled at edge N: entry visible (`empty`=0) after edge N.
- FSM leaves IDLE at edge N+1; `tx` falls in the cycle following edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles.
- Back-to-back frames have zero idle cycles: the start bit of frame k+1 begins exactly 10×`CLKS_PER_BIT` cycles after the start of frame k.
- `busy` rises with the start bit and falls on the edge that enters IDLE.
- `full`, `empty`, `count` and `overflow` are registered and update on the same edge as the push or pop that changes them.
- No combinational path from `dbus` or `out_strobe` to any output.

## Structure
- Shared package `nic8_io_pkg`:
  - `tx_state_t` enum (IDLE, START, DATA, STOP)
  - `UART_DATA_BITS`=8
  - `UART_FRAME_BITS`=10
- Sub-module `sync_fifo`: parameterised width and depth, with push/pop, full/empty/count, and the drop-on-full rule above. It is reusable for a future input port.
- The top level holds the FSM, bit timer, shift register and the `overflow` flag.

## Test plan
- Single byte, `CLKS_PER_BIT`=4: strobe with `dbus`=0x41.
  - Required: `tx` low for 4 cycles, then bits 1,0,0,0,0,0,1,0 (4 cycles each), then high for 4 cycles.
  - `busy` high for exactly 40 cycles; `count` returns to 0.
- Burst, `DEPTH`=8: strobes on 10 consecutive edges with values 0x00..0x09.
  - Required: 0x00..0x08 transmitted in order, 0x09 dropped.
  - `full`=1 after the 9th edge; `overflow`=1 and remains set through later traffic.
- Back-to-back: two strobes (0xFF, 0x00), `CLKS_PER_BIT`=3.
  - Required: second start bit begins exactly 30 cycles after the first; `busy` never drops between the two frames.
- Reset mid-frame: assert `reset`=0 during DATA bit 3 with 2 entries queued.
  - Required: next edge gives `tx`=1, `busy`=0, `empty`=1, `count`=0, `overflow`=0.
  - After release, no further frames are sent.
- `CLKS_PER_BIT`=1 edge case: strobe 0xA5.
  - Required: 10-cycle frame with bits 1,0,1,0,0,1,0,1 after the start bit.
- Push/pop same edge when full: fill to `DEPTH` while the FSM is in STOP, and strobe on the pop edge.
  - Required: strobe dropped, `overflow`=1, `count`=`DEPTH`-1 after that edge.

Source files
------------

// File: rtl/nic8_io_pkg.sv
// Shared types and constants for the nic8 CPU I/O ports.
package nic8_io_pkg;

   localparam int unsigned UART_DATA_BITS  = 8;
   localparam int unsigned UART_FRAME_BITS = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered occupancy count. A push while full is
// dropped (full is judged before any same-edge pop) and flagged on drop_o.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     drop_o
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;
   logic             push_ok, pop_ok;

   // Next pointers and occupancy; flags are derived from the next count so
   // they change on the same edge as the push/pop that causes them.
   always_comb begin
      push_ok  = push_i && !full_q;
      pop_ok   = pop_i && !empty_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == (AW+1)'(DEPTH));
      empty_d = (count_d == '0);
   end

   // Pointer, count and flag registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Storage array; contents need no reset since count gates every read.
   always_ff @(posedge clk_i) begin
      if (rst_ni && push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;
   assign count_o = count_q;
   assign drop_o  = push_i && full_q;

endmodule

// File: rtl/out_port_uart.sv
// CPU OUT-port stage: buffers strobed bus bytes and sends them as 8N1 frames.
module out_port_uart
   import nic8_io_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = 4,
   parameter int unsigned DEPTH        = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              dbus,
   input  logic                    out_strobe,
   output logic                    tx,
   output logic                    full,
   output logic                    empty,
   output logic [$clog2(DEPTH):0]  count,
   output logic                    overflow,
   output logic                    busy
);

   localparam logic [7:0] TIMER_LAST = 8'(CLKS_PER_BIT - 1);
   localparam logic [2:0] BIT_LAST   = 3'(UART_DATA_BITS - 1);

   tx_state_t  state_q, state_d;
   logic [7:0] timer_q, timer_d;
   logic [2:0] bit_idx_q, bit_idx_d;
   logic [7:0] shreg_q, shreg_d;
   logic       ovf_q, ovf_d;
   logic       pop;
   logic       drop;
   logic       fifo_empty;
   logic [7:0] head;
   logic       timer_last;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (out_strobe),
      .data_i  (dbus),
      .pop_i   (pop),
      .data_o  (head),
      .full_o  (full),
      .empty_o (fifo_empty),
      .count_o (count),
      .drop_o  (drop)
   );

   assign timer_last = (timer_q == TIMER_LAST);

   // State, timer, shifter and sticky overflow registers.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shreg_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shreg_q   <= shreg_d;
         ovf_q     <= ovf_d;
      end
   end

   // Next state: the timer restarts at every state or bit change, and the
   // last STOP cycle may chain straight into the next START.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q + 8'd1;
      bit_idx_d = bit_idx_q;
      shreg_d   = shreg_q;
      pop       = 1'b0;
      ovf_d     = ovf_q | drop;
      case (state_q)
         IDLE: begin
            timer_d = '0;
            if (!fifo_empty) begin
               shreg_d = head;
               pop     = 1'b1;
               state_d = START;
            end
         end
         START: begin
            if (timer_last) begin
               timer_d   = '0;
               bit_idx_d = '0;
               state_d   = DATA;
            end
         end
         DATA: begin
            if (timer_last) begin
               timer_d   = '0;
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == BIT_LAST) state_d = STOP;
            end
         end
         STOP: begin
            if (timer_last) begin
               timer_d = '0;
               if (!fifo_empty) begin
                  shreg_d = head;
                  pop     = 1'b1;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level and busy flag from the current state only.
   always_comb begin
      tx   = 1'b1;
      busy = (state_q != IDLE);
      case (state_q)
         START:   tx = 1'b0;
         DATA:    tx = shreg_q[0];
         default: tx = 1'b1;
      endcase
   end

   assign empty    = fifo_empty;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_out_port_uart.sv
// Directed bench for out_port_uart: three instances (CLKS_PER_BIT 4, 3, 1).
module tb_out_port_uart;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] dbus;
   logic [2:0] stb;

   logic       tx4, tx3, tx1, busy4, busy3, busy1, full4, full3, full1;
   logic       empty4, empty3, empty1, ovf4, ovf3, ovf1;
   logic [3:0] cnt4, cnt3, cnt1;

   logic [2:0]      tx_v, busy_v, full_v, empty_v, ovf_v;
   logic [2:0][3:0] cnt_v;

   int n_checks = 0;
   int n_errors = 0;

   assign tx_v    = {tx1, tx3, tx4};
   assign busy_v  = {busy1, busy3, busy4};
   assign full_v  = {full1, full3, full4};
   assign empty_v = {empty1, empty3, empty4};
   assign ovf_v   = {ovf1, ovf3, ovf4};
   assign cnt_v   = {cnt1, cnt3, cnt4};

   always #5 clk = ~clk;

   out_port_uart #(.CLKS_PER_BIT(4), .DEPTH(8)) u_dut4 (
      .clk(clk), .reset(reset), .dbus(dbus), .out_strobe(stb[0]), .tx(tx4),
      .full(full4), .empty(empty4), .count(cnt4), .overflow(ovf4), .busy(busy4));

   out_port_uart #(.CLKS_PER_BIT(3), .DEPTH(8)) u_dut3 (
      .clk(clk), .reset(reset), .dbus(dbus), .out_strobe(stb[1]), .tx(tx3),
      .full(full3), .empty(empty3), .count(cnt3), .overflow(ovf3), .busy(busy3));

   out_port_uart #(.CLKS_PER_BIT(1), .DEPTH(8)) u_dut1 (
      .clk(clk), .reset(reset), .dbus(dbus), .out_strobe(stb[2]), .tx(tx1),
      .full(full1), .empty(empty1), .count(cnt1), .overflow(ovf1), .busy(busy1));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Drive one strobe; the byte is pushed on the next rising edge.
   task automatic strobe_byte(input int s, input logic [7:0] d);
      dbus   = d;
      stb[s] = 1'b1;
      @(posedge clk);
      #1;
      stb[s] = 1'b0;
   endtask

   // Cycle-exact frame check; already=1 means the FSM has already left IDLE.
   task automatic check_frame(input int s, input logic [7:0] d, input int c,
                              input bit already, input bit end_idle, input string tag);
      logic exp;
      int   b;
      if (!already) @(posedge clk);
      for (int i = 0; i < 10 * c; i++) begin
         b = i / c;
         if (i > 0) @(posedge clk);
         @(negedge clk);
         exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
         chk($sformatf("%s_tx_c%0d", tag, i), tx_v[s], exp);
         chk($sformatf("%s_busy_c%0d", tag, i), busy_v[s], 1);
      end
      if (end_idle) begin
         @(posedge clk);
         @(negedge clk);
         chk({tag, "_busy_end"}, busy_v[s], 0);
         chk({tag, "_tx_end"}, tx_v[s], 1);
      end
   endtask

   // Frame receiver: finds a start bit, samples each bit on its first cycle.
   task automatic rx_frame(input int s, input int c, output logic [7:0] d, input string tag);
      int t = 0;
      d = '0;
      @(negedge clk);
      while (tx_v[s] !== 1'b0 && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_start_seen"}, (t < 2000), 1);
      for (int j = 0; j < 8; j++) begin
         repeat (c) @(negedge clk);
         d[j] = tx_v[s];
      end
      repeat (c) @(negedge clk);
      chk({tag, "_stop"}, tx_v[s], 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] rd;
      int lows;
      int busys;

      reset = 1'b0;
      stb   = '0;
      dbus  = '0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) begin
         chk($sformatf("rst%0d_tx", s), tx_v[s], 1);
         chk($sformatf("rst%0d_busy", s), busy_v[s], 0);
         chk($sformatf("rst%0d_empty", s), empty_v[s], 1);
         chk($sformatf("rst%0d_full", s), full_v[s], 0);
         chk($sformatf("rst%0d_count", s), cnt_v[s], 0);
         chk($sformatf("rst%0d_ovf", s), ovf_v[s], 0);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single byte 0x41 at 4 clocks per bit.
      strobe_byte(0, 8'h41);
      chk("single_count_after_push", cnt_v[0], 1);
      chk("single_empty_after_push", empty_v[0], 0);
      chk("single_busy_before_start", busy_v[0], 0);
      check_frame(0, 8'h41, 4, 1'b0, 1'b1, "single");
      chk("single_count_end", cnt_v[0], 0);

      // Burst of 10 strobes: 0x00..0x08 sent, 0x09 dropped.
      @(posedge clk);
      #1;
      fork
         begin
            for (int i = 0; i < 10; i++) begin
               strobe_byte(0, 8'(i));
               if (i == 7) begin
                  chk("burst_full_edge8", full_v[0], 0);
                  chk("burst_count_edge8", cnt_v[0], 7);
               end
               if (i == 8) begin
                  chk("burst_full_edge9", full_v[0], 1);
                  chk("burst_count_edge9", cnt_v[0], 8);
                  chk("burst_ovf_edge9", ovf_v[0], 0);
               end
               if (i == 9) begin
                  chk("burst_ovf_edge10", ovf_v[0], 1);
                  chk("burst_count_edge10", cnt_v[0], 8);
               end
            end
         end
         begin
            for (int k = 0; k < 9; k++) begin
               rx_frame(0, 4, rd, $sformatf("burst_f%0d", k));
               chk($sformatf("burst_data%0d", k), rd, 8'(k));
            end
         end
      join
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx_v[0] == 1'b0) lows++;
      end
      chk("burst_no_tenth_frame", lows, 0);
      chk("burst_empty_after", empty_v[0], 1);
      chk("burst_ovf_sticky", ovf_v[0], 1);
      strobe_byte(0, 8'h55);
      rx_frame(0, 4, rd, "later");
      chk("later_data", rd, 8'h55);
      chk("later_ovf_sticky", ovf_v[0], 1);

      // Reset during DATA bit 3 with two entries queued.
      repeat (10) @(posedge clk);
      #1;
      strobe_byte(0, 8'h11);
      strobe_byte(0, 8'h22);
      strobe_byte(0, 8'h33);
      repeat (16) @(posedge clk);
      #1;
      chk("midrst_busy_before", busy_v[0], 1);
      chk("midrst_count_before", cnt_v[0], 2);
      chk("midrst_tx_bit3", tx_v[0], 0);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_tx", tx_v[0], 1);
      chk("midrst_busy", busy_v[0], 0);
      chk("midrst_empty", empty_v[0], 1);
      chk("midrst_count", cnt_v[0], 0);
      chk("midrst_ovf", ovf_v[0], 0);
      reset = 1'b1;
      lows  = 0;
      busys = 0;
      repeat (80) begin
         @(negedge clk);
         if (tx_v[0] == 1'b0) lows++;
         if (busy_v[0] == 1'b1) busys++;
      end
      chk("midrst_no_tx_after", lows, 0);
      chk("midrst_no_busy_after", busys, 0);

      // Full FIFO while in STOP; strobe lands on the pop edge.
      @(posedge clk);
      #1;
      for (int i = 0; i < 9; i++) strobe_byte(0, 8'(8'h40 + i));
      chk("popfull_count_filled", cnt_v[0], 8);
      chk("popfull_full_filled", full_v[0], 1);
      repeat (32) @(posedge clk);
      #1;
      chk("popfull_busy_stop", busy_v[0], 1);
      chk("popfull_tx_stop", tx_v[0], 1);
      chk("popfull_count_stop", cnt_v[0], 8);
      strobe_byte(0, 8'hEE);
      chk("popfull_ovf", ovf_v[0], 1);
      chk("popfull_count", cnt_v[0], 7);
      chk("popfull_full", full_v[0], 0);
      chk("popfull_next_start", tx_v[0], 0);

      // Back-to-back 0xFF, 0x00 at 3 clocks per bit.
      strobe_byte(1, 8'hFF);
      strobe_byte(1, 8'h00);
      chk("b2b_count", cnt_v[1], 1);
      check_frame(1, 8'hFF, 3, 1'b1, 1'b0, "b2b_f0");
      check_frame(1, 8'h00, 3, 1'b0, 1'b1, "b2b_f1");
      chk("b2b_empty_end", empty_v[1], 1);

      // One clock per bit, 0xA5.
      strobe_byte(2, 8'hA5);
      check_frame(2, 8'hA5, 1, 1'b0, 1'b1, "cpb1");
      chk("cpb1_count_end", cnt_v[2], 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
